branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Generalised conditional-branch engine for the cpu core. Resolves all six RV32I/RV64I
//  branches (BEQ/BNE/BLT/BGE/BLTU/BGEU), computes the target and detects mispredictions.
//  Keeps a BHT of 2-bit saturating counters that the fetch stage reads for predictions.
//  Sits between decode/execute (resolve side) and fetch (predict/redirect side).
// PARAMETERS
//  XLEN         32     datapath/PC width (32 or 64)
//  BHT_ENTRIES  16     counter count; power of two, >=2; IDX_W = log2(BHT_ENTRIES)
//  CNT_INIT     2'b01  counter value after reset/flush sweep (weakly not-taken)
// PORTS
//  clk             in   1     clock, rising edge
//  reset_n         in   1     asynchronous active-low reset
//  bht_flush       in   1     restart BHT clear sweep
//  pred_req        in   1     fetch lookup request
//  pred_pc         in   XLEN  fetch PC
//  pred_valid      out  1     prediction valid (1 cycle after pred_req)
//  pred_taken      out  1     predicted direction (counter[1])
//  res_valid       in   1     resolve request
//  res_ready       out  1     unit accepts resolve (0 during sweep)
//  res_pc          in   XLEN  PC of branch
//  res_funct3      in   3     branch funct3
//  res_rs1,res_rs2 in   XLEN  operands
//  res_imm         in   XLEN  sign-extended B-immediate
//  res_pred_taken  in   1     direction fetch assumed
//  out_valid       out  1     result pulse, 1 cycle after accept
//  out_taken       out  1     actual direction
//  out_mispredict  out  1     redirect required
//  out_redirect_pc out  XLEN  correct next PC
//  out_illegal     out  1     funct3 = 010/011
//  out_misaligned  out  1     taken, target[1:0]!=0
//  stat_branches   out  32    accepted legal branches, saturating
//  stat_mispred    out  32    mispredicts, saturating
// BEHAVIOUR
//  Reset: all outputs 0; FSM=SWEEP, sweep ptr=0; stat counters 0.
//  FSM SWEEP: writes CNT_INIT to entry ptr each cycle, ptr++; after entry BHT_ENTRIES-1
//   -> RUN (exactly BHT_ENTRIES cycles). res_ready=0; pred_valid pulses with pred_taken=0.
//  RUN: res_ready=1. bht_flush in any state -> SWEEP, ptr=0 next cycle; a resolve
//   accepted in the same cycle as flush is dropped (no out_valid, no stats).
//  Accept = res_valid & res_ready. Index = pc[IDX_W+1:2] for both ports.
//  Compare: EQ rs1==rs2; NE !=; LT/GE signed; LTU/GEU unsigned; full XLEN.
//  target = res_pc+res_imm, pc4 = res_pc+4, both modulo 2^XLEN (wrap, no flag).
//  Illegal funct3: taken=0, out_illegal=1, no BHT update, no stat increment;
//   mispredict = res_pred_taken, redirect = pc4.
//  Misaligned: taken & target[1]|target[0] -> out_misaligned=1, out_mispredict=0,
//   no BHT update; stat_branches counts it.
//  Legal, aligned: mispredict = taken ^ res_pred_taken; redirect = taken ? target : pc4
//   (driven even when no mispredict). Counter +1 if taken else -1, saturating 0..3.
//  All out_* registered, valid exactly one cycle after accept; otherwise out_* hold 0.
//  pred_taken registered from BHT before same-edge update: predict & resolve on
//   same index in one cycle returns the old counter.
//  Back-to-back resolves on one index each see the prior update (no lost writes).
//  Stat counters stick at 32'hFFFF_FFFF.
//  reset_n low mid-operation: immediate return to reset state, in-flight result lost.
// TESTING
//  1 Reset, count cycles -> res_ready rises after exactly 16 cycles; pred_taken=0 all idx.
//  2 BEQ rs1=2,rs2=2,pc=0x10,imm=-16,pred=0 -> taken=1,mispredict=1,redirect=0x0, 1 cyc.
//  3 BLT rs1=0xFFFFFFFF,rs2=1 -> taken; BLTU same operands -> not taken, redirect=pc+4.
//  4 Three taken BNE at pc=0x40 -> counter 01->10->11->11; pred at 0x40 returns 1 after
//    1st update; same-cycle predict/resolve returns old value.
//  5 funct3=3'b010, pred=1 -> illegal=1,mispredict=1,redirect=pc+4, stats unchanged;
//    BEQ taken with imm=2 -> misaligned=1, mispredict=0.
//  6 pc=0xFFFFFFFC,imm=8 taken -> redirect=0x4; bht_flush mid-stream -> ready=0 16 cycles,
//    counters back to 01; reset_n pulse during out_valid -> all outputs 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Conditional-branch resolver with a 2-bit BHT read by fetch.
// Ports: fetch predict (pred_*), resolve in (res_*), result (out_*), stats.
module branch_resolve_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter logic [1:0]  CNT_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            bht_flush,
  input  logic            pred_req,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic [XLEN-1:0] res_pc,
  input  logic [2:0]      res_funct3,
  input  logic [XLEN-1:0] res_rs1,
  input  logic [XLEN-1:0] res_rs2,
  input  logic [XLEN-1:0] res_imm,
  input  logic            res_pred_taken,
  output logic            out_valid,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic [XLEN-1:0] out_redirect_pc,
  output logic            out_illegal,
  output logic            out_misaligned,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic            valid;
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] redirect;
    logic            illegal;
    logic            misaligned;
  } res_t;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [1:0]         bht_q [BHT_ENTRIES];
  logic [1:0]         bht_d [BHT_ENTRIES];
  res_t               res_q, res_d;
  logic               pv_q, pv_d;
  logic               pt_q, pt_d;
  logic [31:0]        sb_q, sb_d;
  logic [31:0]        sm_q, sm_d;

  logic [IDX_W-1:0]   p_idx;
  logic [IDX_W-1:0]   r_idx;
  logic               accept;
  logic               illegal;
  logic               cond;
  logic               taken;
  logic               misal;
  logic               upd;
  logic [XLEN-1:0]    target;
  logic [XLEN-1:0]    pc4;
  logic [1:0]         cur;

  logic               unused_bits;
  assign unused_bits = ^{pred_pc[XLEN-1:IDX_W+2],
                         pred_pc[1:0]};

  assign p_idx = pred_pc[IDX_W+1:2];
  assign r_idx = res_pc[IDX_W+1:2];

  assign res_ready = (state_q == RUN);

  // A resolve coinciding with a flush is discarded.
  assign accept = res_valid & res_ready & ~bht_flush;

  assign target = res_pc + res_imm;
  assign pc4    = res_pc + XLEN'(4);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    unique case (res_funct3)
      3'b000: cond = (res_rs1 == res_rs2);
      3'b001: cond = (res_rs1 != res_rs2);
      3'b100: cond = ($signed(res_rs1) <  $signed(res_rs2));
      3'b101: cond = ($signed(res_rs1) >= $signed(res_rs2));
      3'b110: cond = (res_rs1 <  res_rs2);
      3'b111: cond = (res_rs1 >= res_rs2);
      3'b010,
      3'b011: illegal = 1'b1;
    endcase
  end

  assign taken = cond & ~illegal;
  assign misal = taken & (target[1] | target[0]);
  assign upd   = accept & ~illegal & ~misal;
  assign cur   = bht_q[r_idx];

  // Sweep / run control
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      SWEEP: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(BHT_ENTRIES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ptr_d = '0;
      end
    endcase
    if (bht_flush) begin
      state_d = SWEEP;
      ptr_d   = '0;
    end
  end

  // Sweep writes and resolve updates never overlap:
  // resolves are only accepted in RUN.
  always_comb begin
    bht_d = bht_q;
    if (state_q == SWEEP) begin
      bht_d[ptr_q] = CNT_INIT;
    end else if (upd) begin
      if (taken) begin
        bht_d[r_idx] = (cur == 2'b11) ? cur : cur + 2'b01;
      end else begin
        bht_d[r_idx] = (cur == 2'b00) ? cur : cur - 2'b01;
      end
    end
  end

  // Prediction reads the pre-update counter.
  always_comb begin
    pv_d = pred_req;
    pt_d = pred_req & (state_q == RUN) & bht_q[p_idx][1];
  end

  always_comb begin
    res_d = '0;
    if (accept) begin
      res_d.valid      = 1'b1;
      res_d.taken      = taken;
      res_d.illegal    = illegal;
      res_d.misaligned = misal;
      res_d.redirect   = taken ? target : pc4;
      if (illegal) begin
        res_d.mispredict = res_pred_taken;
      end else if (misal) begin
        res_d.mispredict = 1'b0;
      end else begin
        res_d.mispredict = taken ^ res_pred_taken;
      end
    end
  end

  always_comb begin
    sb_d = sb_q;
    sm_d = sm_q;
    if (accept && !illegal && sb_q != '1) begin
      sb_d = sb_q + 32'd1;
    end
    if (upd && (taken ^ res_pred_taken) && sm_q != '1) begin
      sm_d = sm_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
      res_q   <= '0;
      pv_q    <= 1'b0;
      pt_q    <= 1'b0;
      sb_q    <= '0;
      sm_q    <= '0;
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i] <= CNT_INIT;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      res_q   <= res_d;
      pv_q    <= pv_d;
      pt_q    <= pt_d;
      sb_q    <= sb_d;
      sm_q    <= sm_d;
      bht_q   <= bht_d;
    end
  end

  assign pred_valid      = pv_q;
  assign pred_taken      = pt_q;
  assign out_valid       = res_q.valid;
  assign out_taken       = res_q.taken;
  assign out_mispredict  = res_q.mispredict;
  assign out_redirect_pc = res_q.redirect;
  assign out_illegal     = res_q.illegal;
  assign out_misaligned  = res_q.misaligned;
  assign stat_branches   = sb_q;
  assign stat_mispred    = sm_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed steps then random
// resolves/predicts checked against a behavioural model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bht_flush;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc;
  logic [2:0]  res_funct3;
  logic [31:0] res_rs1;
  logic [31:0] res_rs2;
  logic [31:0] res_imm;
  logic        res_pred_taken;
  logic        out_valid;
  logic        out_taken;
  logic        out_mispredict;
  logic [31:0] out_redirect_pc;
  logic        out_illegal;
  logic        out_misaligned;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int vectors = 0;
  int errors  = 0;

  int     cnt [16];
  longint sb;
  longint sm;

  branch_resolve_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bht_flush       (bht_flush),
    .pred_req        (pred_req),
    .pred_pc         (pred_pc),
    .pred_valid      (pred_valid),
    .pred_taken      (pred_taken),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_pc          (res_pc),
    .res_funct3      (res_funct3),
    .res_rs1         (res_rs1),
    .res_rs2         (res_rs2),
    .res_imm         (res_imm),
    .res_pred_taken  (res_pred_taken),
    .out_valid       (out_valid),
    .out_taken       (out_taken),
    .out_mispredict  (out_mispredict),
    .out_redirect_pc (out_redirect_pc),
    .out_illegal     (out_illegal),
    .out_misaligned  (out_misaligned),
    .stat_branches   (stat_branches),
    .stat_mispred    (stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    int sa;
    int sb_;
    sa  = a;
    sb_ = b;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb_;
      3'd5:    return sa >= sb_;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) cnt[i] = 1;
  endtask

  // Counts edges until res_ready rises; optionally probes
  // a prediction in the first sweep cycle.
  task automatic wait_sweep(input bit probe);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (probe && i == 1) begin
        pred_req = 1'b1;
        pred_pc  = 32'h40;
      end
      @(posedge clk);
      #1;
      pred_req = 1'b0;
      if (probe && i == 1) begin
        chk("sweep_pv", pred_valid, 1);
        chk("sweep_pt", pred_taken, 0);
      end
      chk("sweep_nores", out_valid, 0);
      if (res_ready) begin
        n = i;
        break;
      end
    end
    chk("sweep_len", n, 16);
    model_clear();
  endtask

  task automatic do_pred(input logic [31:0] pc);
    pred_req = 1'b1;
    pred_pc  = pc;
    @(posedge clk);
    #1;
    pred_req = 1'b0;
    chk("pred_valid", pred_valid, 1);
    chk("pred_taken", pred_taken, cnt[idx_of(pc)] >= 2);
  endtask

  task automatic do_idle();
    @(posedge clk);
    #1;
    chk("idle_valid", out_valid, 0);
    chk("idle_outs",
        {out_taken, out_mispredict, out_redirect_pc,
         out_illegal, out_misaligned}, 0);
  endtask

  task automatic do_res(input logic [31:0] pc,
                        input logic [2:0]  f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] imm,
                        input bit          pt,
                        input bit          also_pred);
    bit          legal;
    bit          tk;
    bit          mis;
    bit          mp;
    bit          old_bit;
    logic [31:0] tgt;
    logic [31:0] p4;
    int          ix;
    legal = !(f3 == 3'b010 || f3 == 3'b011);
    tk    = legal && ref_taken(f3, a, b);
    tgt   = pc + imm;
    p4    = pc + 32'd4;
    mis   = tk && (tgt % 4 != 0);
    ix    = idx_of(pc);
    old_bit = cnt[ix] >= 2;
    if (!legal) mp = pt;
    else if (mis) mp = 1'b0;
    else mp = tk ^ pt;
    res_valid      = 1'b1;
    res_pc         = pc;
    res_funct3     = f3;
    res_rs1        = a;
    res_rs2        = b;
    res_imm        = imm;
    res_pred_taken = pt;
    if (also_pred) begin
      pred_req = 1'b1;
      pred_pc  = pc;
    end
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    pred_req  = 1'b0;
    chk("out_valid", out_valid, 1);
    chk("out_taken", out_taken, tk);
    chk("out_illegal", out_illegal, !legal);
    chk("out_misaligned", out_misaligned, mis);
    chk("out_mispredict", out_mispredict, mp);
    if (!mis) begin
      chk("out_redirect", out_redirect_pc, tk ? tgt : p4);
    end
    if (also_pred) begin
      chk("same_cyc_pred", pred_taken, old_bit);
    end
    if (legal && !mis) begin
      if (tk) cnt[ix] = (cnt[ix] == 3) ? 3 : cnt[ix] + 1;
      else    cnt[ix] = (cnt[ix] == 0) ? 0 : cnt[ix] - 1;
      if (tk != pt) sm++;
    end
    if (legal) sb++;
    chk("stat_branches", stat_branches, sb);
    chk("stat_mispred", stat_mispred, sm);
  endtask

  initial begin
    reset_n        = 1'b0;
    bht_flush      = 1'b0;
    pred_req       = 1'b0;
    pred_pc        = '0;
    res_valid      = 1'b0;
    res_pc         = '0;
    res_funct3     = '0;
    res_rs1        = '0;
    res_rs2        = '0;
    res_imm        = '0;
    res_pred_taken = 1'b0;
    sb = 0;
    sm = 0;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", res_ready, 0);
    chk("rst_pv", pred_valid, 0);
    chk("rst_outs",
        {out_valid, out_taken, out_mispredict,
         out_redirect_pc, out_illegal, out_misaligned}, 0);
    chk("rst_stats", {stat_branches, stat_mispred}, 0);
    reset_n = 1'b1;
    wait_sweep(1'b1);

    for (int i = 0; i < 16; i++) do_pred(32'(i * 4));

    // BEQ taken, wraps to 0
    do_res(32'h10, 3'd0, 2, 2, 32'hFFFF_FFF0, 0, 0);
    chk("t2_redirect", out_redirect_pc, 32'h0);
    chk("t2_mispredict", out_mispredict, 1);
    do_idle();

    // Signed vs unsigned
    do_res(32'h20, 3'd4, 32'hFFFF_FFFF, 1, 32'h100, 0, 0);
    chk("t3_blt", out_taken, 1);
    do_res(32'h20, 3'd6, 32'hFFFF_FFFF, 1, 32'h100, 0, 0);
    chk("t3_bltu", out_taken, 0);
    chk("t3_pc4", out_redirect_pc, 32'h24);

    // Counter training at 0x40
    do_pred(32'h40);
    do_res(32'h40, 3'd1, 1, 2, 32'h20, 0, 1);
    do_pred(32'h40);
    do_res(32'h40, 3'd1, 1, 2, 32'h20, 1, 1);
    do_res(32'h40, 3'd1, 1, 2, 32'h20, 1, 0);
    do_res(32'h40, 3'd1, 3, 3, 32'h20, 1, 0);
    do_pred(32'h40);
    do_res(32'h40, 3'd1, 3, 3, 32'h20, 1, 0);
    do_pred(32'h40);
    do_res(32'h40, 3'd1, 1, 2, 32'h20, 0, 0);
    do_res(32'h40, 3'd1, 1, 2, 32'h20, 0, 0);

    // Illegal and misaligned
    do_res(32'h80, 3'b010, 5, 5, 32'h40, 1, 0);
    chk("t5_illegal", out_illegal, 1);
    chk("t5_redirect", out_redirect_pc, 32'h84);
    do_res(32'h80, 3'b011, 5, 6, 32'h40, 0, 0);
    do_res(32'h80, 3'd0, 7, 7, 32'h2, 1, 0);
    chk("t5_misal", out_misaligned, 1);
    chk("t5_nomp", out_mispredict, 0);

    // PC wrap
    do_res(32'hFFFF_FFFC, 3'd0, 9, 9, 32'h8, 0, 0);
    chk("t6_wrap", out_redirect_pc, 32'h4);

    // Flush with a colliding resolve, which must be dropped
    bht_flush      = 1'b1;
    res_valid      = 1'b1;
    res_pc         = 32'h40;
    res_funct3     = 3'd0;
    res_rs1        = 0;
    res_rs2        = 0;
    res_imm        = 32'h8;
    res_pred_taken = 1'b0;
    @(posedge clk);
    #1;
    bht_flush = 1'b0;
    res_valid = 1'b0;
    chk("flush_drop", out_valid, 0);
    chk("flush_ready", res_ready, 0);
    chk("flush_stat", stat_branches, sb);
    wait_sweep(1'b1);
    do_pred(32'h40);
    chk("flush_cnt", pred_taken, 0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      int          act;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      act = $urandom_range(0, 9);
      pc  = ($urandom_range(0, 3) == 0) ?
            ($urandom & 32'hFFFF_FFFC) :
            32'($urandom_range(0, 47)) << 2;
      a   = $urandom;
      b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
      imm = 32'($urandom_range(0, 511)) * 2 - 32'd512;
      if (act < 6) begin
        do_res(pc, 3'($urandom_range(0, 7)), a, b, imm,
               1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0);
      end else if (act < 9) begin
        do_pred(pc);
      end else begin
        do_idle();
      end
    end

    // Reset while a result is on the outputs
    do_res(32'h10, 3'd0, 1, 1, 32'h10, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_outs",
        {out_valid, out_taken, out_mispredict,
         out_redirect_pc, out_illegal, out_misaligned}, 0);
    chk("mid_rst_stats", {stat_branches, stat_mispred}, 0);
    chk("mid_rst_ready", res_ready, 0);
    chk("mid_rst_pv", pred_valid, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb = 0;
    sm = 0;
    wait_sweep(1'b0);
    do_res(32'h40, 3'd5, 4, 3, 32'h8, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
